// File: rtl/mem_burst_master.sv
// Burst initiator for the 8x8 single-port memory: accepts burst commands,
// streams write beats to the memory port, and buffers read beats in a small
// response FIFO so that backpressure throttles issue instead of losing data.
module mem_burst_master #(
  parameter int unsigned AW = 3,
  parameter int unsigned DW = 8,
  parameter int unsigned LW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_write_i,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic [LW-1:0] cmd_len_i,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  input  logic [DW-1:0] wr_data_i,
  output logic          rd_valid_o,
  input  logic          rd_ready_i,
  output logic [DW-1:0] rd_data_o,
  output logic          rd_last_o,
  output logic          busy_o,
  output logic          mem_op_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam int unsigned FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR      = 2'd1,
    ST_RD      = 2'd2,
    ST_RD_WAIT = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          inflight_q, inflight_d;
  logic          infl_last_q, infl_last_d;

  logic          cmd_ready_q, cmd_ready_d;
  logic          wr_ready_q, wr_ready_d;
  logic          busy_q, busy_d;
  logic          mem_op_q, mem_op_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic [DW-1:0] fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_q;
  logic          fifo_head_q, fifo_tail_q;
  logic [1:0]    fifo_cnt_q;

  logic          cmd_fire, wr_fire, rd_push, rd_pop, rd_issue, last_beat;
  logic [2:0]    rd_occ;

  // Handshakes and read-issue throttle (occupancy after this cycle's pop)
  assign cmd_fire  = cmd_valid_i & cmd_ready_q;
  assign wr_fire   = wr_valid_i & wr_ready_q;
  assign rd_push   = inflight_q;
  assign rd_pop    = rd_valid_o & rd_ready_i;
  assign rd_occ    = 3'(fifo_cnt_q) + 3'(inflight_q) - 3'(rd_pop);
  assign rd_issue  = (state_q == ST_RD) && (rd_occ < 3'd2);
  assign last_beat = (cnt_q == '0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) state_d = cmd_write_i ? ST_WR : ST_RD;
      end
      ST_WR: begin
        if (wr_fire && last_beat) state_d = ST_IDLE;
      end
      ST_RD: begin
        if (rd_issue && last_beat) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        // The final beat is captured into the FIFO on this edge.
        if (inflight_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    cmd_ready_d = (state_d == ST_IDLE);
    wr_ready_d  = (state_d == ST_WR);
    busy_d      = (state_d != ST_IDLE);
    mem_op_d    = wr_fire;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    inflight_d  = rd_issue;
    infl_last_d = rd_issue & last_beat;

    if (wr_fire || rd_issue) begin
      mem_addr_d = ptr_q;
      ptr_d      = ptr_q + AW'(1);
      cnt_d      = cnt_q - LW'(1);
    end
    if (wr_fire) mem_wdata_d = wr_data_i;
    if (cmd_fire) begin
      ptr_d = cmd_addr_i;
      cnt_d = cmd_len_i;
    end
  end

  // Registered outputs, burst pointer/counter and in-flight tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      mem_op_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      cmd_ready_q <= cmd_ready_d;
      wr_ready_q  <= wr_ready_d;
      busy_q      <= busy_d;
      mem_op_q    <= mem_op_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
    end
  end

  // Two-entry response FIFO; captures the in-flight beat one edge after issue
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_data_q[i] <= '0;
      fifo_last_q <= '0;
      fifo_head_q <= 1'b0;
      fifo_tail_q <= 1'b0;
      fifo_cnt_q  <= '0;
    end else begin
      if (rd_push) begin
        fifo_data_q[fifo_tail_q] <= mem_rdata_i;
        fifo_last_q[fifo_tail_q] <= infl_last_q;
        fifo_tail_q              <= ~fifo_tail_q;
      end
      if (rd_pop) fifo_head_q <= ~fifo_head_q;
      fifo_cnt_q <= fifo_cnt_q + 2'(rd_push) - 2'(rd_pop);
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign wr_ready_o  = wr_ready_q;
  assign busy_o      = busy_q;
  assign mem_op_o    = mem_op_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign rd_valid_o  = (fifo_cnt_q != '0);
  assign rd_data_o   = fifo_data_q[fifo_head_q];
  assign rd_last_o   = fifo_last_q[fifo_head_q];

endmodule
